// File: rtl/game_round_sequencer.sv
// Round/phase controller for the VGA shooter: rounds R1..R4, lives, intermission and hit-freeze windows.
// Optional per-round time limit is compiled in when ROUND_TIMEOUT_EN is defined.
module game_round_sequencer #(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned INTER_CYCLES = 50_000_000,
    parameter int unsigned HIT_CYCLES   = 25_000_000,
    parameter int unsigned ROUND_CYCLES = 1_500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] won,
    input  logic       collided,
    output logic [5:0] state,
    output logic [1:0] lives,
    output logic       freeze,
    output logic       round_start,
    output logic       game_won,
    output logic       game_over
);
    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_R1   = 6'b000010,
        S_R2   = 6'b000100,
        S_R3   = 6'b001000,
        S_R4   = 6'b010000,
        S_DONE = 6'b100000
    } state_t;
    typedef enum logic [1:0] {PLAY, INTER, HIT} phase_t;

    state_t      st;
    phase_t      phase;
    logic [31:0] counter;
    logic        armed;
    logic        start_q;
    logic        start_rise;
    logic        won_cur;
    logic        timeout;
    logic        lose;

`ifdef ROUND_TIMEOUT_EN
    localparam logic [31:0] TIMER_LOAD = 32'(ROUND_CYCLES - 1);
    logic [31:0] timer;
    assign timeout = (timer == 32'd0);
`else
    assign timeout = 1'b0;
`endif

    assign start_rise = start & ~start_q;
    // One-hot round bits line up with won[0..3], so masking selects the current round's flag.
    assign won_cur    = |(won & st[4:1]);
    assign lose       = (phase == PLAY) && !won_cur && (timeout || (collided && armed));
    assign state      = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st          <= S_IDLE;
            phase       <= PLAY;
            counter     <= '0;
            armed       <= 1'b1;
            start_q     <= 1'b0;
            lives       <= 2'(LIVES_INIT);
            freeze      <= 1'b0;
            round_start <= 1'b0;
            game_won    <= 1'b0;
            game_over   <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
            timer       <= '0;
`endif
        end else begin
            start_q     <= start;
            round_start <= 1'b0;
            case (st)
                S_IDLE: if (start_rise) begin
                    st          <= S_R1;
                    phase       <= PLAY;
                    round_start <= 1'b1;
`ifdef ROUND_TIMEOUT_EN
                    timer       <= TIMER_LOAD;
`endif
                end
                S_DONE: if (start_rise) begin
                    st        <= S_IDLE;
                    lives     <= 2'(LIVES_INIT);
                    game_won  <= 1'b0;
                    game_over <= 1'b0;
                    armed     <= 1'b1;
                end
                default: begin
                    case (phase)
                        PLAY: begin
                            // A continuous overlap must be seen clear once before it can cost another life.
                            if (lose)
                                armed <= 1'b0;
                            else if (!collided)
                                armed <= 1'b1;
                            if (won_cur) begin
                                phase   <= INTER;
                                counter <= 32'(INTER_CYCLES - 1);
                                freeze  <= 1'b1;
                            end else if (lose) begin
                                if (lives == 2'd1) begin
                                    lives     <= 2'd0;
                                    st        <= S_DONE;
                                    game_over <= 1'b1;
                                    freeze    <= 1'b0;
                                end else begin
                                    lives   <= lives - 2'd1;
                                    phase   <= HIT;
                                    counter <= 32'(HIT_CYCLES - 1);
                                    freeze  <= 1'b1;
                                end
                            end
`ifdef ROUND_TIMEOUT_EN
                            else
                                timer <= timer - 32'd1;
`endif
                        end
                        INTER: if (counter == 32'd0) begin
                            freeze <= 1'b0;
                            if (st == S_R4) begin
                                st       <= S_DONE;
                                game_won <= 1'b1;
                            end else begin
                                st          <= state_t'({st[4:0], 1'b0});
                                phase       <= PLAY;
                                round_start <= 1'b1;
`ifdef ROUND_TIMEOUT_EN
                                timer       <= TIMER_LOAD;
`endif
                            end
                        end else begin
                            counter <= counter - 32'd1;
                        end
                        HIT: if (counter == 32'd0) begin
                            freeze <= 1'b0;
                            phase  <= PLAY;
`ifdef ROUND_TIMEOUT_EN
                            timer  <= TIMER_LOAD;
`endif
                        end else begin
                            counter <= counter - 32'd1;
                        end
                        default: phase <= PLAY;
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_round_sequencer.sv
// Self-checking bench for game_round_sequencer: directed scenarios plus random stimulus
// compared every cycle against a round/lives/window-count reference model.
module tb_game_round_sequencer;
    localparam int LI = 3;
    localparam int IC = 4;
    localparam int HC = 3;
    localparam int RC = 10;
`ifdef ROUND_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int HOLD  = 12;
`else
    localparam bit TO_EN = 1'b0;
    localparam int HOLD  = 20;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] won = 4'd0;
    logic       collided = 1'b0;
    logic [5:0] state;
    logic [1:0] lives;
    logic       freeze, round_start, game_won, game_over;

    game_round_sequencer #(
        .LIVES_INIT(LI), .INTER_CYCLES(IC), .HIT_CYCLES(HC), .ROUND_CYCLES(RC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .won(won), .collided(collided),
        .state(state), .lives(lives), .freeze(freeze), .round_start(round_start),
        .game_won(game_won), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: round 0 = idle, 1..4 = rounds, 5 = done; mode 0 play, 1 intermission, 2 hit.
    int m_round, m_mode, m_left, m_tleft, m_lives;
    bit m_won, m_over, m_rs, m_armed, m_prev;

    wire [11:0] dut_vec = {state, lives, freeze, round_start, game_won, game_over};

    function automatic logic [11:0] mdl_vec();
        logic [5:0] s;
        logic       f;
        s = 6'd1 << m_round;
        f = (m_round >= 1 && m_round <= 4 && m_mode != 0);
        return {s, 2'(m_lives), f, m_rs, m_won, m_over};
    endfunction

    task automatic model_reset();
        m_round = 0; m_mode = 0; m_left = 0; m_tleft = 0; m_lives = LI;
        m_won = 0; m_over = 0; m_rs = 0; m_armed = 1; m_prev = 0;
    endtask

    task automatic model_step(input logic s, input logic [3:0] w, input logic c);
        bit rise, lost;
        rise = s && !m_prev;
        m_prev = s;
        m_rs = 0;
        lost = 0;
        if (m_round == 0) begin
            if (rise) begin m_round = 1; m_mode = 0; m_rs = 1; m_tleft = RC; end
        end else if (m_round == 5) begin
            if (rise) begin m_round = 0; m_lives = LI; m_won = 0; m_over = 0; m_armed = 1; end
        end else if (m_mode != 0) begin
            m_left--;
            if (m_left == 0) begin
                if (m_mode == 1 && m_round == 4) begin
                    m_round = 5; m_won = 1;
                end else begin
                    if (m_mode == 1) begin m_round++; m_rs = 1; end
                    m_mode = 0; m_tleft = RC;
                end
            end
        end else begin
            if (w[m_round-1]) begin m_mode = 1; m_left = IC; end
            else if (TO_EN && m_tleft == 1) lost = 1;
            else if (c && m_armed) lost = 1;
            else m_tleft--;
            if (lost) begin
                m_armed = 0;
                if (m_lives == 1) begin m_lives = 0; m_round = 5; m_over = 1; end
                else begin m_lives--; m_mode = 2; m_left = HC; end
            end else if (!c) begin
                m_armed = 1;
            end
        end
    endtask

    task automatic step(input logic s, input logic [3:0] w, input logic c);
        start = s; won = w; collided = c;
        @(posedge clk);
        model_step(s, w, c);
        #1;
    endtask

    task automatic do_reset();
        start = 0; won = 0; collided = 0;
        @(negedge clk);
        reset = 1;
        #2;
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        start = 0; won = 0; collided = 0;
        @(negedge clk);
        reset = 1;
        #1;
        model_reset();
        vectors++;
        if (dut_vec !== 12'b000001_11_0000) begin
            miscompares++;
            $display("FAIL reset_values got=%b want=%b", dut_vec, 12'b000001_11_0000);
        end
        @(negedge clk);
        reset = 0;
        step(0, 0, 0);
        vectors++;
        if (dut_vec !== mdl_vec()) begin
            miscompares++;
            $display("FAIL reset_idle got=%b want=%b", dut_vec, mdl_vec());
        end
    endtask

    task automatic test_start();
        do_reset();
        step(1, 0, 0);
        vectors++;
        if (state !== 6'b000010 || round_start !== 1'b1 || lives !== 2'd3) begin
            miscompares++;
            $display("FAIL start_enter got state=%b rs=%b lives=%0d want 000010 1 3", state, round_start, lives);
        end
        step(1, 0, 0);
        vectors++;
        if (state !== 6'b000010 || round_start !== 1'b0) begin
            miscompares++;
            $display("FAIL start_pulse got state=%b rs=%b want 000010 0", state, round_start);
        end
        step(0, 0, 0);
        step(1, 0, 0);
        vectors++;
        if (dut_vec !== mdl_vec() || state !== 6'b000010) begin
            miscompares++;
            $display("FAIL start_ignored got=%b want=%b", dut_vec, mdl_vec());
        end
    endtask

    task automatic test_rounds();
        int fcnt;
        do_reset();
        step(1, 0, 0);
        for (int n = 0; n < 4; n++) begin
            step(0, 4'(1 << n), 0);
            fcnt = 1;
            vectors++;
            if (freeze !== 1'b1) begin
                miscompares++;
                $display("FAIL round%0d_inter got freeze=%b want 1", n + 1, freeze);
            end
            for (int k = 0; k < 10; k++) begin
                step(0, 0, 0);
                vectors++;
                if (dut_vec !== mdl_vec()) begin
                    miscompares++;
                    $display("FAIL round%0d_vec got=%b want=%b", n + 1, dut_vec, mdl_vec());
                end
                if (!freeze) break;
                fcnt++;
            end
            vectors++;
            if (fcnt !== IC) begin
                miscompares++;
                $display("FAIL round%0d_freeze_len got=%0d want=%0d", n + 1, fcnt, IC);
            end
            vectors++;
            if (n < 3) begin
                if (state !== (6'd1 << (n + 2)) || round_start !== 1'b1) begin
                    miscompares++;
                    $display("FAIL round%0d_next got state=%b rs=%b want %b 1", n + 1, state, round_start, 6'd1 << (n + 2));
                end
            end else if (state !== 6'b100000 || game_won !== 1'b1 || game_over !== 1'b0) begin
                miscompares++;
                $display("FAIL game_won got state=%b won=%b over=%b want 100000 1 0", state, game_won, game_over);
            end
        end
    endtask

    task automatic test_collision();
        int fcnt;
        do_reset();
        step(1, 0, 0);
        step(0, 4'b0001, 0);
        for (int k = 0; k < IC; k++) step(0, 0, 0);
        fcnt = 0;
        for (int k = 0; k < HOLD; k++) begin
            step(0, 0, 1);
            if (freeze) fcnt++;
            vectors++;
            if (dut_vec !== mdl_vec()) begin
                miscompares++;
                $display("FAIL hold_vec cyc=%0d got=%b want=%b", k, dut_vec, mdl_vec());
            end
        end
        vectors++;
        if (lives !== 2'd2 || fcnt !== HC || state !== 6'b000100) begin
            miscompares++;
            $display("FAIL hold_once got lives=%0d freeze_len=%0d state=%b want 2 %0d 000100", lives, fcnt, state, HC);
        end
        step(0, 0, 0);
        step(0, 0, 1);
        vectors++;
        if (lives !== 2'd1 || freeze !== 1'b1) begin
            miscompares++;
            $display("FAIL rearm got lives=%0d freeze=%b want 1 1", lives, freeze);
        end
        for (int k = 0; k < HC + 1; k++) step(0, 0, 0);
        step(0, 0, 1);
        vectors++;
        if (lives !== 2'd0 || state !== 6'b100000 || game_over !== 1'b1 || freeze !== 1'b0) begin
            miscompares++;
            $display("FAIL game_over got lives=%0d state=%b over=%b freeze=%b want 0 100000 1 0", lives, state, game_over, freeze);
        end
        step(1, 0, 0);
        vectors++;
        if (dut_vec !== 12'b000001_11_0000) begin
            miscompares++;
            $display("FAIL restart got=%b want=%b", dut_vec, 12'b000001_11_0000);
        end
    endtask

    task automatic test_priority();
        do_reset();
        step(1, 0, 0);
        step(0, 4'b0001, 1);
        vectors++;
        if (freeze !== 1'b1 || lives !== 2'd3 || state !== 6'b000010) begin
            miscompares++;
            $display("FAIL won_over_collide got freeze=%b lives=%0d state=%b want 1 3 000010", freeze, lives, state);
        end
        step(0, 0, 1);
        step(0, 0, 1);
        #3;
        reset = 1;
        #1;
        model_reset();
        vectors++;
        if (dut_vec !== 12'b000001_11_0000) begin
            miscompares++;
            $display("FAIL async_reset got=%b want=%b", dut_vec, 12'b000001_11_0000);
        end
        @(negedge clk);
        reset = 0;
        collided = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        step(1, 0, 0);
`ifdef ROUND_TIMEOUT_EN
        for (int k = 0; k < RC - 1; k++) step(0, 0, 0);
        vectors++;
        if (lives !== 2'd3 || freeze !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early got lives=%0d freeze=%b want 3 0", lives, freeze);
        end
        step(0, 0, 0);
        vectors++;
        if (lives !== 2'd2 || freeze !== 1'b1 || state !== 6'b000010) begin
            miscompares++;
            $display("FAIL timeout_hit got lives=%0d freeze=%b state=%b want 2 1 000010", lives, freeze, state);
        end
        for (int k = 0; k < HC; k++) step(0, 0, 0);
        for (int k = 0; k < RC - 1; k++) step(0, 0, 0);
        vectors++;
        if (lives !== 2'd2) begin
            miscompares++;
            $display("FAIL timeout_reload got lives=%0d want 2", lives);
        end
        step(0, 0, 0);
        vectors++;
        if (lives !== 2'd1 || freeze !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_second got lives=%0d freeze=%b want 1 1", lives, freeze);
        end
`else
        for (int k = 0; k < 100; k++) step(0, 0, 0);
        vectors++;
        if (lives !== 2'd3 || state !== 6'b000010 || freeze !== 1'b0) begin
            miscompares++;
            $display("FAIL no_timeout got lives=%0d state=%b freeze=%b want 3 000010 0", lives, state, freeze);
        end
`endif
    endtask

    task automatic test_random();
        logic       s, c;
        logic [3:0] w;
        do_reset();
        c = 0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            s = ($urandom_range(0, 7) == 0);
            w = ($urandom_range(0, 11) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
            if ($urandom_range(0, 5) == 0) c = ~c;
            step(s, w, c);
            vectors++;
            if (dut_vec !== mdl_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b want=%b", k, dut_vec, mdl_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_rounds();
        test_collision();
        test_priority();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
